mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide sequencer for the five-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from stage E.
- Holds the HI/LO registers and runs each multi-cycle operation as a counted busy window.
- Exports `busy` so the stall unit can hold any HI/LO-dependent instruction in D until the result commits.

## Interface
- `MULT_CYCLES`, default 5: busy duration for MULT/MULTU; legal range 1..15.
- `DIV_CYCLES`, default 10: busy duration for DIV/DIVU; legal range 1..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  stage E holds a valid HI/LO-writing instruction this cycle.
- `md_op`  in  3  operation code:
  - 0 = none, 1 = MULT, 2 = MULTU, 3 = DIV, 4 = DIVU, 5 = MTHI, 6 = MTLO.
  - 7 is reserved and treated as none.
- `a`  in  32  forwarded rs value from E.
- `b`  in  32  forwarded rt value from E.
- `busy`  out  1  a multiply or divide is in flight.
- `done`  out  1  one-cycle pulse in the first cycle in which the new HI/LO are visible.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE and BUSY. A 4-bit down-counter `cnt` tracks the BUSY window.
- Accepting a command (IDLE):
  - `start=1` with `md_op` in 1..4 is accepted on the clock edge.
  - The 64-bit result is computed from `a`/`b` at accept time and latched into pending registers.
  - `cnt` is loaded with the op's cycle count; the state moves to BUSY.
- MTHI/MTLO (IDLE): `start=1` with `md_op`=5/6 writes `a` into `hi`/`lo` on the same edge. There is no BUSY phase and no `done` pulse.
- `start=1` with `md_op`=0 or 7 has no effect.
- BUSY, each edge: `cnt` decrements. On the edge where `cnt==1`:
  - `hi`/`lo` take the pending value.
  - The state returns to IDLE and `done` is set for one cycle.
- `start` during BUSY is ignored. The stall unit guarantees that no HI/LO instruction reaches E while `start|busy` is asserted.
- Multiply results:
  - MULT: signed 32x32 to 64; `hi` = upper 32 bits, `lo` = lower 32 bits.
  - MULTU: unsigned 32x32 to 64, same split.
- Divide results:
  - DIV (signed): `lo` = quotient truncated toward zero; `hi` = remainder, carrying the sign of the dividend.
  - DIV special case: 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
  - DIVU: unsigned; `lo` = quotient, `hi` = remainder.
  - Divisor 0: pending value = current `hi`/`lo`, so the registers are unchanged at commit. The full DIV_CYCLES window is still taken (see Configuration).
- Reset (any time, including mid-operation):
  - State = IDLE, `cnt`=0, `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - Pending registers are cleared and the in-flight operation is discarded.

## Timing
- Accept edge at cycle t: `busy` is high for exactly N cycles, t+1 through t+N, where N is the op's cycle count.
- The commit edge ends cycle t+N. The new `hi`/`lo` and `done=1` are visible in cycle t+N+1, with `busy=0`.
- Back-to-back: a new `start` in cycle t+N+1 is accepted.
- MTHI/MTLO at cycle t: the new value is visible in cycle t+1.
- `busy`, `done`, `hi` and `lo` are all register outputs; there is no combinational path from any input.
- Reads of `hi`/`lo` (MFHI/MFLO in E) must be stalled while `start|busy`. When not stalled, they read the register outputs directly.

## Configuration
- Macro `MDU_DIV0_FAST_EN`:
  - Defined: DIV/DIVU with `b`==0 loads `cnt`=1, so `busy` lasts 1 cycle, then `done` pulses and `hi`/`lo` are unchanged.
  - Undefined: a divide by zero takes the full DIV_CYCLES like any other divide.

## Test plan
- MULT, a=0xFFFFFFFE (-2), b=3 -> `busy` high for 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, `done` pulses once.
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles, `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> `busy` for 10 cycles, then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Separately, DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Preload `hi`=0x12345678 via MTHI (visible next cycle, `busy` stays 0), then DIVU by 0:
  - Macro undefined: `busy` 10 cycles.
  - Macro defined: `busy` 1 cycle.
  - Both cases: `hi`=0x12345678 and `lo` unchanged afterwards.
- DIV started, `start` with MULT pulsed in busy cycle 3 -> ignored. Assert `reset`=0 in busy cycle 6 -> `busy`, `done`, `hi` and `lo` go to 0 immediately. After release, no commit occurs.

Source files
------------

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl - multiply/divide sequencer for the five-stage pipeline.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from stage E. It owns the HI/LO
// registers and runs each multiply or divide as a counted busy window. The
// result is computed and latched into pending registers on the accept edge.
// It is copied into HI/LO on the last edge of the window.
//
// Parameters:
//   MULT_CYCLES  busy window length for MULT/MULTU (1..15)
//   DIV_CYCLES   busy window length for DIV/DIVU   (1..15)
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous active-low reset
//   start  in   1   E holds a valid HI/LO-writing instruction
//   md_op  in   3   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//   a      in  32   forwarded rs
//   b      in  32   forwarded rt
//   busy   out  1   multiply/divide in flight
//   done   out  1   one-cycle pulse, first cycle the new HI/LO are visible
//   hi     out 32   HI register
//   lo     out 32   LO register
//
// Optional feature macro: MDU_DIV0_FAST_EN. When it is defined, a divide by
// zero finishes after a single busy cycle.
//
// Handshake: start is sampled only in IDLE. While busy is high, start is
// ignored. The stall unit holds HI/LO users in D while start|busy.
// -----------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

`ifdef MDU_DIV0_FAST_EN
  localparam logic [3:0] DIV0_CNT = 4'd1;
`else
  localparam logic [3:0] DIV0_CNT = DIV_CNT;
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic        done_q, done_d;

  // Arithmetic on the accept-cycle operands.
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, uq, ur;
  logic [31:0] sq, sr, dq, dr;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide uses magnitudes. The quotient is negated when the operand
    // signs differ. The remainder takes the sign of the dividend. With this
    // method 0x80000000 / -1 gives lo=0x80000000 and hi=0 without a special
    // case.
    a_mag = a[31] ? (32'd0 - a) : a;
    b_mag = b[31] ? (32'd0 - b) : b;
    uq    = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    ur    = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    sq    = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
    sr    = a[31] ? (32'd0 - ur) : ur;

    dq    = (b == 32'd0) ? 32'd0 : (a / b);
    dr    = (b == 32'd0) ? 32'd0 : (a % b);
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              {phi_d, plo_d} = prod_s;
              cnt_d          = MULT_CNT;
              state_d        = S_BUSY;
            end
            OP_MULTU: begin
              {phi_d, plo_d} = prod_u;
              cnt_d          = MULT_CNT;
              state_d        = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_BUSY;
              if (b == 32'd0) begin
                // Committing the current HI/LO leaves the registers unchanged.
                phi_d = hi_q;
                plo_d = lo_q;
                cnt_d = DIV0_CNT;
              end else begin
                cnt_d = DIV_CNT;
                if (md_op == OP_DIV) begin
                  phi_d = sr;
                  plo_d = sq;
                end else begin
                  phi_d = dr;
                  plo_d = dq;
                end
              end
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // The window also closes at cnt==0 so the FSM cannot get stuck.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          hi_d    = phi_q;
          lo_d    = plo_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl - self-checking bench for mdu_ctrl (default cycle counts 5/10).
// Expected {hi,lo} values come from a longint reference model. Each value is
// pushed when an op is driven and popped when done is seen.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MDU_DIV0_FAST_EN
  localparam int DIV0_N = 1;
`else
  localparam int DIV0_N = DIV_N;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [31:0] model_hi, model_lo;
  int          n_checks;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result for a multiply/divide, in {hi,lo} form.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, q, r;
    longint ux, uy;
    logic [63:0] res;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'({32'd0, x});
    uy  = longint'({32'd0, y});
    res = {model_hi, model_lo};
    case (op)
      3'd1: res = 64'(sx * sy);
      3'd2: res = 64'(ux * uy);
      3'd3: if (y != 0) begin
        q   = sx / sy;
        r   = sx % sy;
        res = {r[31:0], q[31:0]};
      end
      3'd4: if (y != 0) begin
        q   = ux / uy;
        r   = ux % uy;
        res = {r[31:0], q[31:0]};
      end
      default: ;
    endcase
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  // Each task is entered just after a falling edge and leaves just after one.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int n_exp);
    logic [63:0] e;
    int n;
    exp_q.push_back(ref_result(op, x, y));
    start = 1'b1; md_op = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    check_eq({tag, "_done_low"}, 64'(done), 64'd0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, 64'(n), 64'(n_exp));
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_hilo"}, {hi, lo}, e);
      model_hi = e[63:32];
      model_lo = e[31:0];
    end
  endtask

  task automatic run_mt(input string tag, input logic is_hi, input logic [31:0] x);
    start = 1'b1; md_op = is_hi ? 3'd5 : 3'd6; a = x; b = $urandom;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    if (is_hi) model_hi = x; else model_lo = x;
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_hilo"}, {hi, lo}, {model_hi, model_lo});
  endtask

  // ---------------- stimulus ----------------
  int done_seen;

  initial begin
    n_checks = 0; n_fail = 0;
    model_hi = 0; model_lo = 0;
    start = 0; md_op = 0; a = 0; b = 0;
    reset = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    reset = 1;
    @(negedge clk);

    // Directed vectors.
    run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, MULT_N);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, DIV_N);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N);
    run_op("divu", 3'd4, 32'd100, 32'd7, DIV_N);

    // None / reserved codes must have no effect.
    start = 1; md_op = 3'd0; a = 32'hDEAD_BEEF; b = 32'd1;
    @(negedge clk);
    md_op = 3'd7;
    @(negedge clk);
    start = 0;
    check_eq("nop_busy", 64'(busy), 64'd0);
    check_eq("nop_hilo", {hi, lo}, {model_hi, model_lo});

    // MTHI / MTLO, then divide by zero keeps the registers unchanged.
    run_mt("mthi", 1'b1, 32'h1234_5678);
    run_mt("mtlo", 1'b0, 32'h0BAD_F00D);
    run_op("divu_zero", 3'd4, 32'h0000_0055, 32'd0, DIV0_N);
    run_op("div_zero", 3'd3, 32'hFFFF_0000, 32'd0, DIV0_N);

    // Back-to-back random operations.
    for (int i = 0; i < 12; i++) begin
      logic [2:0] op;
      logic [31:0] x, y;
      op = 3'($urandom_range(1, 4));
      x  = $urandom;
      y  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 9));
      if (op >= 3'd3)
        run_op("rand_div", op, x, y, (y == 0) ? DIV0_N : DIV_N);
      else
        run_op("rand_mul", op, x, y, MULT_N);
    end

    // start during BUSY is ignored; reset mid-operation discards the op.
    start = 1; md_op = 3'd3; a = 32'd1000; b = 32'd3;
    @(negedge clk);                 // busy cycle 1
    start = 0; md_op = 0;
    @(negedge clk);                 // busy cycle 2
    @(negedge clk);                 // busy cycle 3
    start = 1; md_op = 3'd1; a = 32'd7; b = 32'd9;
    @(negedge clk);                 // busy cycle 4
    start = 0; md_op = 0;
    check_eq("ign_busy", 64'(busy), 64'd1);
    @(negedge clk);                 // busy cycle 5
    @(negedge clk);                 // busy cycle 6
    reset = 0;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_done", 64'(done), 64'd0);
    check_eq("arst_hilo", {hi, lo}, 64'd0);
    model_hi = 0; model_lo = 0;
    @(negedge clk);
    reset = 1;
    done_seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check_eq("no_commit", 64'(done_seen), 64'd0);
    check_eq("post_hilo", {hi, lo}, 64'd0);

    // A new op after reset still works.
    run_op("post_mult", 3'd1, 32'h7FFF_FFFF, 32'h8000_0000, MULT_N);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
